instr_sequencer: RTL



---
 rtl/instr_sequencer_pkg.sv | 35 +++
 rtl/instr_sequencer_if.sv | 44 ++++
 rtl/instr_sequencer_tick_gen.sv | 28 ++
 rtl/instr_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, instruction field
// positions and FSM state encoding. Used by instr_sequencer (optional feature
// macro SINGLE_STEP_EN is handled in the top and interface, not here).
package seq_pkg;

  // Opcodes carried in instruction bits [31:28]
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_HALT = 4'b1110;
  localparam logic [3:0] OP_OUT  = 4'b1111;

  // Instruction field bit positions
  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 28;
  localparam int unsigned RA_MSB  = 27;
  localparam int unsigned RA_LSB  = 24;
  localparam int unsigned RB_MSB  = 23;
  localparam int unsigned RB_LSB  = 20;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  // FSM state encoding
  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_FETCH     = 3'd0;
  localparam logic [STATE_W-1:0] ST_DECODE    = 3'd1;
  localparam logic [STATE_W-1:0] ST_EXECUTE   = 3'd2;
  localparam logic [STATE_W-1:0] ST_WRITEBACK = 3'd3;
  localparam logic [STATE_W-1:0] ST_HALT      = 3'd4;

  // Opcodes that produce a register-file write and a displayed result
  function automatic logic writes_rf(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus between the sequencer and its environment (instruction store, regfile,
// result display). With SINGLE_STEP_EN defined the bus also carries `step`.
interface instr_sequencer_if #(
  parameter int unsigned PC_W = 3
);

  logic            run;
  logic [31:0]     instruction;
  logic [PC_W-1:0] pc;
  logic [3:0]      rf_addr_a;
  logic [3:0]      rf_addr_b;
  logic [31:0]     rf_data_a;
  logic [31:0]     rf_data_b;
  logic            rf_we;
  logic [3:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic [31:0]     result;
  logic            result_valid;
  logic            halted;
`ifdef SINGLE_STEP_EN
  logic            step;
`endif

`ifdef SINGLE_STEP_EN
  modport master (
    input  run, instruction, rf_data_a, rf_data_b, step,
    output pc, rf_addr_a, rf_addr_b, rf_we, rf_waddr, rf_wdata, result, result_valid, halted
  );
  modport slave (
    output run, instruction, rf_data_a, rf_data_b, step,
    input  pc, rf_addr_a, rf_addr_b, rf_we, rf_waddr, rf_wdata, result, result_valid, halted
  );
`else
  modport master (
    input  run, instruction, rf_data_a, rf_data_b,
    output pc, rf_addr_a, rf_addr_b, rf_we, rf_waddr, rf_wdata, result, result_valid, halted
  );
  modport slave (
    output run, instruction, rf_data_a, rf_data_b,
    input  pc, rf_addr_a, rf_addr_b, rf_we, rf_waddr, rf_wdata, result, result_valid, halted
  );
`endif

endinterface

// File: rtl/instr_sequencer_tick_gen.sv
// Prescaler: one-clk tick every TICK_DIV clocks; constantly high when TICK_DIV == 1.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntMax);

  // Count 0..TICK_DIV-1 and wrap on the tick cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer: FETCH -> DECODE -> EXECUTE -> WRITEBACK, one step per
// prescaler tick, with a sticky HALT. Defining SINGLE_STEP_EN adds bus.step,
// which (with run=0) arms exactly one instruction per rising edge.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned PC_W     = 3,
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_sequencer_if.master   bus
);

  logic               tick;
  logic [STATE_W-1:0] state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        alu_q, alu_d;
  logic [31:0]        result_q, result_d;
  logic [3:0]         op;
  logic               fetch_go;
  logic               rf_we;
  logic               result_valid;
  logic               unused_instr_bits;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign op                = instr_q[OP_MSB:OP_LSB];
  assign unused_instr_bits = ^instr_q[19:16];

`ifdef SINGLE_STEP_EN
  logic step_q;
  logic armed_q, armed_d;

  assign fetch_go = bus.run | armed_q;

  // Arm one fetch on a step rising edge while idle in FETCH; the fetch consumes it
  always_comb begin
    armed_d = armed_q;
    if ((state_q == ST_FETCH) && !bus.run && bus.step && !step_q) begin
      armed_d = 1'b1;
    end
    if (tick && (state_q == ST_FETCH) && fetch_go) begin
      armed_d = 1'b0;
    end
  end

  // Step edge detector and arm flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      step_q  <= bus.step;
      armed_q <= armed_d;
    end
  end
`else
  assign fetch_go = bus.run;
`endif

  // Next-state logic; strobes are combinational so they only exist in a tick cycle
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    alu_d        = alu_q;
    result_d     = result_q;
    rf_we        = 1'b0;
    result_valid = 1'b0;
    if (tick) begin
      case (state_q)
        ST_FETCH: begin
          if (fetch_go) begin
            instr_d = bus.instruction;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_d = ST_EXECUTE;
        end
        ST_EXECUTE: begin
          state_d = ST_WRITEBACK;
          case (op)
            OP_ADDI: alu_d = {16'h0000, instr_q[IMM_MSB:IMM_LSB]};
            OP_ADD:  alu_d = bus.rf_data_a + bus.rf_data_b;
            OP_OUT: begin
              result_d     = bus.rf_data_a;
              result_valid = 1'b1;
            end
            OP_HALT: state_d = ST_HALT;
            default: ;
          endcase
        end
        ST_WRITEBACK: begin
          if (writes_rf(op)) begin
            rf_we        = 1'b1;
            result_d     = alu_q;
            result_valid = 1'b1;
          end
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_FETCH;
        end
        ST_HALT: ;
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // Architectural state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      instr_q  <= '0;
      alu_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      alu_q    <= alu_d;
      result_q <= result_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.rf_addr_a    = instr_q[RA_MSB:RA_LSB];
  assign bus.rf_addr_b    = instr_q[RB_MSB:RB_LSB];
  assign bus.rf_we        = rf_we;
  assign bus.rf_waddr     = instr_q[RA_MSB:RA_LSB];
  assign bus.rf_wdata     = alu_q;
  // Show the incoming value during the valid pulse so data and strobe line up
  assign bus.result       = result_d;
  assign bus.result_valid = result_valid;
  assign bus.halted       = (state_q == ST_HALT);

endmodule
